// File: rtl/sam_mem_pkg.sv
// Shared types for the CPU/device memory arbiter: FSM states and requester ids.
package sam_mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DEV = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a port whose access just completed is masked out,
// and on a tie the port that was not served last wins.
module rr_arb2
   import sam_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  logic       upd,
   input  logic       upd_id,
   output logic       gnt_vld,
   output logic       gnt_id
);

   logic       last_grant;
   logic [1:0] elig;

   assign elig = req & ~mask;

   always_comb begin
      gnt_vld = |elig;
      gnt_id  = PORT_CPU;
      if (elig == 2'b11) begin
         gnt_id = ~last_grant;
      end else if (elig[PORT_DEV]) begin
         gnt_id = PORT_DEV;
      end
   end

   // Reset value makes the CPU win the very first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= PORT_DEV;
      end else if (upd) begin
         last_grant <= upd_id;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port fixed-latency memory between the CPU and one DMA/IO device,
// one access in flight; wait_ stalls the micro-sequencer, the device gets a one-cycle ack.
module mem_arbiter #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              wait_,
   input  logic              dev_req,
   input  logic              dev_we,
   input  logic [ADDR_W-1:0] dev_addr,
   input  logic [DATA_W-1:0] dev_wdata,
   output logic [DATA_W-1:0] dev_rdata,
   output logic              dev_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   import sam_mem_pkg::*;

   localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              own_q, own_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dev_rdata_q, dev_rdata_d;
   logic              cpu_done_q, cpu_done_d;
   logic              dev_done_q, dev_done_d;
   logic              gnt_vld, gnt_id, upd;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (reset),
      .req     ({dev_req, cpu_req}),
      .mask    ({dev_done_q, cpu_done_q}),
      .upd     (upd),
      .upd_id  (own_q),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      own_d       = own_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dev_rdata_d = dev_rdata_q;
      cpu_done_d  = 1'b0;
      dev_done_d  = 1'b0;
      upd         = 1'b0;

      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               own_d    = gnt_id;
               mem_en_d = 1'b1;
               cnt_d    = CNT_INIT;
               state_d  = BUSY;
               if (gnt_id == PORT_DEV) begin
                  mem_we_d = dev_we;
                  addr_d   = dev_addr;
                  wdata_d  = dev_wdata;
               end else begin
                  mem_we_d = cpu_we;
                  addr_d   = cpu_addr;
                  wdata_d  = cpu_wdata;
               end
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Last access cycle: mem_rdata is valid now, the done pulse lands in the next (IDLE) cycle.
               if (own_q == PORT_DEV) begin
                  dev_done_d = 1'b1;
                  if (!mem_we_q) dev_rdata_d = mem_rdata;
               end else begin
                  cpu_done_d = 1'b1;
                  if (!mem_we_q) cpu_rdata_d = mem_rdata;
               end
               upd      = 1'b1;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         own_q       <= PORT_CPU;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dev_rdata_q <= '0;
         cpu_done_q  <= 1'b0;
         dev_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         own_q       <= own_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dev_rdata_q <= dev_rdata_d;
         cpu_done_q  <= cpu_done_d;
         dev_done_q  <= dev_done_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dev_rdata = dev_rdata_q;
   assign dev_ack   = dev_done_q;
   assign wait_     = cpu_req & ~cpu_done_q;

endmodule
